// File: rtl/dl_ram_pkg.sv
// Shared definitions for the downlink ping-pong RAM write and read controllers.
package dl_ram_pkg;

    localparam int unsigned DATA_W      = 10;
    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned FRAME_WORDS = 38;
    localparam int unsigned IDX_W       = 6;
    localparam int unsigned OVF_W       = 16;

    localparam logic [ADDR_W-1:0] BUF0_BASE = 7'd0;
    localparam logic [ADDR_W-1:0] BUF1_BASE = 7'd64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_DROP = 2'd2
    } wr_fsm_e;

endpackage

// File: rtl/dl_ram_buf_tracker.sv
// Per-buffer full flag: set by the writer, cleared by a rising read-done level.
module dl_ram_buf_tracker (
    input  logic clk,
    input  logic nRst,
    input  logic set_full,
    input  logic rd_state_i,
    output logic wr_state_o,
    output logic free_o
);

    logic rd_d;
    logic rel_q;
    logic full_q;

    // Release is registered once more so the writer sees it as a single decision
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rd_d   <= 1'b0;
            rel_q  <= 1'b0;
            full_q <= 1'b0;
        end else begin
            rd_d  <= rd_state_i;
            rel_q <= rd_state_i & ~rd_d;
            if (set_full) begin
                full_q <= 1'b1;
            end else if (rel_q && full_q) begin
                full_q <= 1'b0;
            end
        end
    end

    assign wr_state_o = full_q;
    assign free_o     = ~full_q;

endmodule

// File: rtl/dl_ram_wr_control.sv
// Packs the input word stream into 38-word frames written alternately into
// the two halves of the downlink ping-pong RAM; drops frames when the target is unread.
module dl_ram_wr_control
    import dl_ram_pkg::*;
(
    input  logic              clk,
    input  logic              nRst,
    input  logic              dinValid,
    input  logic              dinSof,
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        DlRAM_rd_state,
    output logic [1:0]        DlRAM_wr_state,
    output logic              wrRAMEn,
    output logic [ADDR_W-1:0] wrRAMAddr,
    output logic [DATA_W-1:0] wrRAMData,
    output logic              ovfPulse,
    output logic [OVF_W-1:0]  ovfCount,
    output logic              sofErrPulse
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    wr_fsm_e           state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, wr_idx;
    logic              tgt_q, tgt_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        buf_free;
    logic              tgt_free;
    logic              sof_hit;
    logic              wr_en_d, ovf_d, sof_err_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic [OVF_W-1:0]  ovf_cnt_d;

    for (genvar i = 0; i < 2; i++) begin : g_buf
        dl_ram_buf_tracker u_trk (
            .clk        (clk),
            .nRst       (nRst),
            .set_full   (done_q[i]),
            .rd_state_i (DlRAM_rd_state[i]),
            .wr_state_o (DlRAM_wr_state[i]),
            .free_o     (buf_free[i])
        );
    end

    assign tgt_free = tgt_q ? buf_free[1] : buf_free[0];
    assign sof_hit  = dinValid & dinSof;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DROP: begin
                if (sof_hit) begin
                    state_d = tgt_free ? S_WR : S_DROP;
                end
            end
            S_WR: begin
                if (dinValid && !dinSof && idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write port, index, target and drop accounting for the next cycle
    always_comb begin
        idx_d     = idx_q;
        tgt_d     = tgt_q;
        done_d    = 2'b00;
        wr_en_d   = 1'b0;
        wr_idx    = '0;
        ovf_d     = 1'b0;
        sof_err_d = 1'b0;
        ovf_cnt_d = ovfCount;
        case (state_q)
            S_IDLE, S_DROP: begin
                if (sof_hit) begin
                    if (tgt_free) begin
                        wr_en_d = 1'b1;
                        idx_d   = IDX_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                        if (ovfCount != '1) begin
                            ovf_cnt_d = ovfCount + OVF_W'(1);
                        end
                    end
                end
            end
            S_WR: begin
                if (dinValid) begin
                    wr_en_d = 1'b1;
                    if (dinSof) begin
                        sof_err_d = 1'b1;
                        idx_d     = IDX_W'(1);
                    end else begin
                        wr_idx = idx_q;
                        if (idx_q == LAST_IDX) begin
                            idx_d          = '0;
                            tgt_d          = ~tgt_q;
                            done_d[tgt_q]  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
        wr_addr_d = wr_en_d ? (tgt_q ? BUF1_BASE : BUF0_BASE) + ADDR_W'(wr_idx) : wrRAMAddr;
        wr_data_d = wr_en_d ? din : wrRAMData;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            idx_q       <= '0;
            tgt_q       <= 1'b0;
            done_q      <= 2'b00;
            wrRAMEn     <= 1'b0;
            wrRAMAddr   <= '0;
            wrRAMData   <= '0;
            ovfPulse    <= 1'b0;
            ovfCount    <= '0;
            sofErrPulse <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            tgt_q       <= tgt_d;
            done_q      <= done_d;
            wrRAMEn     <= wr_en_d;
            wrRAMAddr   <= wr_addr_d;
            wrRAMData   <= wr_data_d;
            ovfPulse    <= ovf_d;
            ovfCount    <= ovf_cnt_d;
            sofErrPulse <= sof_err_d;
        end
    end

endmodule

// File: tb/tb_dl_ram_wr_control.sv
// Directed bench for dl_ram_wr_control: frame-level vector table plus hand-written corner sequences.
module tb_dl_ram_wr_control;

    logic        clk = 1'b0;
    logic        nRst;
    logic        dinValid;
    logic        dinSof;
    logic [9:0]  din;
    logic [1:0]  DlRAM_rd_state;
    logic [1:0]  DlRAM_wr_state;
    logic        wrRAMEn;
    logic [6:0]  wrRAMAddr;
    logic [9:0]  wrRAMData;
    logic        ovfPulse;
    logic [15:0] ovfCount;
    logic        sofErrPulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dl_ram_wr_control dut (
        .clk            (clk),
        .nRst           (nRst),
        .dinValid       (dinValid),
        .dinSof         (dinSof),
        .din            (din),
        .DlRAM_rd_state (DlRAM_rd_state),
        .DlRAM_wr_state (DlRAM_wr_state),
        .wrRAMEn        (wrRAMEn),
        .wrRAMAddr      (wrRAMAddr),
        .wrRAMData      (wrRAMData),
        .ovfPulse       (ovfPulse),
        .ovfCount       (ovfCount),
        .sofErrPulse    (sofErrPulse)
    );

    typedef struct {
        logic [1:0]  rd_pulse;
        logic        exp_write;
        logic [6:0]  base;
        int          restart_at;
        logic [1:0]  ws_before;
        logic [1:0]  ws_after;
        logic [15:0] ovf_after;
    } frame_vec_t;

    frame_vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_bufs(input logic [1:0] mask);
        DlRAM_rd_state = mask;
        repeat (21) step();
        DlRAM_rd_state = 2'b00;
        repeat (2) step();
    endtask

    task automatic run_frame(input logic exp_write, input logic [6:0] base, input int restart_at,
                             input logic [1:0] ws_before, input logic [1:0] ws_after);
        int total;
        int widx;
        logic [9:0] d;
        total = (restart_at > 0) ? restart_at + 38 : 38;
        widx  = 0;
        for (int k = 0; k < total; k++) begin
            d        = 10'($urandom);
            dinValid = 1'b1;
            dinSof   = (k == 0) || (k == restart_at);
            din      = d;
            if (k == restart_at && k > 0) widx = 0;
            step();
            chk("wr_en", 32'(wrRAMEn), 32'(exp_write));
            if (exp_write) begin
                chk("wr_addr", 32'(wrRAMAddr), 32'(base + 7'(widx)));
                chk("wr_data", 32'(wrRAMData), 32'(d));
            end
            chk("sof_err", 32'(sofErrPulse), 32'(exp_write && k == restart_at && k > 0));
            chk("ovf_pulse", 32'(ovfPulse), 32'(!exp_write && k == 0));
            chk("ws_during", 32'(DlRAM_wr_state), 32'(ws_before));
            widx++;
        end
        dinValid = 1'b0;
        dinSof   = 1'b0;
        step();
        chk("ws_after", 32'(DlRAM_wr_state), 32'(ws_after));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ws"},   32'(DlRAM_wr_state), 32'd0);
        chk({tag, "_en"},   32'(wrRAMEn),        32'd0);
        chk({tag, "_addr"}, 32'(wrRAMAddr),      32'd0);
        chk({tag, "_data"}, 32'(wrRAMData),      32'd0);
        chk({tag, "_ovfp"}, 32'(ovfPulse),       32'd0);
        chk({tag, "_ovfc"}, 32'(ovfCount),       32'd0);
        chk({tag, "_sofe"}, 32'(sofErrPulse),    32'd0);
    endtask

    initial begin
        // rd_pulse, write?, base, restart_at, ws_before, ws_after, ovfCount after
        tbl[0] = '{2'b00, 1'b1, 7'd0,  0,  2'b00, 2'b01, 16'd0};
        tbl[1] = '{2'b01, 1'b1, 7'd64, 0,  2'b00, 2'b10, 16'd0};
        tbl[2] = '{2'b00, 1'b1, 7'd0,  0,  2'b10, 2'b11, 16'd0};
        tbl[3] = '{2'b00, 1'b0, 7'd64, 0,  2'b11, 2'b11, 16'd1};
        tbl[4] = '{2'b10, 1'b1, 7'd64, 20, 2'b01, 2'b11, 16'd1};
        tbl[5] = '{2'b11, 1'b1, 7'd0,  0,  2'b00, 2'b01, 16'd1};
        tbl[6] = '{2'b10, 1'b1, 7'd64, 0,  2'b01, 2'b11, 16'd1};

        nRst           = 1'b0;
        dinValid       = 1'b0;
        dinSof         = 1'b0;
        din            = '0;
        DlRAM_rd_state = 2'b00;
        repeat (3) step();
        chk_all_zero("reset");
        nRst = 1'b1;

        // Words without SOF while idle are ignored
        dinValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = 10'(k + 5);
            step();
            chk("idle_no_sof_en", 32'(wrRAMEn), 32'd0);
        end
        dinValid = 1'b0;
        step();

        for (int t = 0; t < 7; t++) begin
            if (tbl[t].rd_pulse != 2'b00) release_bufs(tbl[t].rd_pulse);
            chk("ws_before", 32'(DlRAM_wr_state), 32'(tbl[t].ws_before));
            run_frame(tbl[t].exp_write, tbl[t].base, tbl[t].restart_at,
                      tbl[t].ws_before, tbl[t].ws_after);
            chk("ovf_count", 32'(ovfCount), 32'(tbl[t].ovf_after));
        end

        // Release latency: still full one edge after the rise is seen, clear the edge after
        DlRAM_rd_state = 2'b01;
        step();
        chk("rel_lat_m", 32'(DlRAM_wr_state), 32'b11);
        step();
        chk("rel_lat_m1", 32'(DlRAM_wr_state), 32'b10);
        repeat (19) step();
        DlRAM_rd_state = 2'b00;
        repeat (2) step();

        // Fill buffer 0 again, then race a buffer-1 release against an SOF
        run_frame(1'b1, 7'd0, 0, 2'b10, 2'b11);
        DlRAM_rd_state = 2'b10;
        step();
        chk("race_ws_m", 32'(DlRAM_wr_state), 32'b11);
        dinValid = 1'b1;
        dinSof   = 1'b1;
        din      = 10'h155;
        step();
        chk("race_ws", 32'(DlRAM_wr_state), 32'b01);
        chk("race_en", 32'(wrRAMEn), 32'd0);
        chk("race_ovfp", 32'(ovfPulse), 32'd1);
        chk("race_ovfc", 32'(ovfCount), 32'd2);
        dinValid = 1'b0;
        dinSof   = 1'b0;
        repeat (19) step();
        DlRAM_rd_state = 2'b00;
        repeat (2) step();
        run_frame(1'b1, 7'd64, 0, 2'b01, 2'b11);

        // Reset in the middle of a buffer-1 frame while buffer 0 is full
        release_bufs(2'b11);
        run_frame(1'b1, 7'd0, 0, 2'b00, 2'b01);
        for (int k = 0; k < 16; k++) begin
            dinValid = 1'b1;
            dinSof   = (k == 0);
            din      = 10'(k + 100);
            if (k < 15) step();
        end
        chk("pre_reset_en", 32'(wrRAMEn), 32'd1);
        #2;
        nRst = 1'b0;
        #1;
        chk_all_zero("midreset");
        dinValid = 1'b0;
        dinSof   = 1'b0;
        step();
        nRst = 1'b1;
        step();
        run_frame(1'b1, 7'd0, 0, 2'b00, 2'b01);

        // Saturate the drop counter
        run_frame(1'b1, 7'd64, 0, 2'b01, 2'b11);
        dinValid = 1'b1;
        dinSof   = 1'b1;
        step();
        chk("sat_first", 32'(ovfCount), 32'd1);
        repeat (65534) step();
        chk("sat_max", 32'(ovfCount), 32'hFFFF);
        step();
        chk("sat_hold", 32'(ovfCount), 32'hFFFF);
        chk("sat_pulse", 32'(ovfPulse), 32'd1);
        chk("sat_en", 32'(wrRAMEn), 32'd0);
        chk("sat_ws", 32'(DlRAM_wr_state), 32'b11);
        dinValid = 1'b0;
        dinSof   = 1'b0;
        step();
        chk("sat_pulse_end", 32'(ovfPulse), 32'd0);
        chk("sat_hold_end", 32'(ovfCount), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dl_ram_wr_control.md
# dl_ram_wr_control

Upstream write controller for the downlink ping-pong RAM. It packs an incoming word stream into fixed 38-word frames. Frames are written alternately into buffer 0 (addresses 0–37) and buffer 1 (addresses 64–101). A buffer is flagged full on `DlRAM_wr_state`, and released only when the downstream read controller acknowledges on `DlRAM_rd_state`. Frames that arrive while the target buffer is still unread are dropped and counted.

## Interface
- `DATA_W`, 10: data word width.
- `ADDR_W`, 7: RAM address width.
- `FRAME_WORDS`, 38: words per frame.
- `BUF0_BASE`, 7'd0: buffer 0 base address.
- `BUF1_BASE`, 7'd64: buffer 1 base address.
- `clk`  in  1: clock clk.
- `nRst`  in  1: reset nRst, asynchronous, active-low.
- `dinValid`  in  1: input word valid.
- `dinSof`  in  1: start of frame; qualified by `dinValid`.
- `din`  in  DATA_W: input word.
- `DlRAM_rd_state`  in  2: per-buffer "read done" level from the read controller. It stays high ≥20 cycles.
- `DlRAM_wr_state`  out  2: per-buffer "full, ready to read" level.
- `wrRAMEn`  out  1: RAM write enable.
- `wrRAMAddr`  out  ADDR_W: RAM write address.
- `wrRAMData`  out  DATA_W: RAM write data.
- `ovfPulse`  out  1: one-cycle pulse when a frame is dropped.
- `ovfCount`  out  16: dropped-frame count, saturates at 16'hFFFF.
- `sofErrPulse`  out  1: one-cycle pulse when a partial frame is abandoned by an early SOF.

## Operation
- Reset values:
  - All outputs 0.
  - Both buffers free.
  - Target buffer = 0.
  - State S_IDLE.
- States:
  - S_IDLE: wait for a frame start.
  - S_WR: filling the target buffer; word index `idx` runs 0..37.
  - S_DROP: discarding a frame.
- S_IDLE, on `dinValid & dinSof`:
  - If the target buffer is free, write the word at idx 0 and go to S_WR.
  - Otherwise pulse `ovfPulse`, increment `ovfCount` and go to S_DROP.
  - Non-SOF words are discarded silently.
- S_WR, on each `dinValid`: write `din` to base(target)+idx, then idx++.
  - The write at idx 37 completes the frame:
    - mark the target full;
    - set `DlRAM_wr_state[target]`;
    - toggle the target;
    - go to S_IDLE.
  - A `dinSof` while idx ∈ 1..37 restarts the frame:
    - pulse `sofErrPulse`;
    - the partial frame is abandoned and the buffer stays free;
    - this SOF word is written at idx 0 of the same buffer;
    - `wr_state` is not set.
- S_DROP: ignore words until the next `dinValid & dinSof`, which is then evaluated exactly as in S_IDLE.
- Release:
  - Register `DlRAM_rd_state` once to get `rd_d`. The release event is `rd_state[i] & ~rd_d[i]`.
  - A release with `wr_state[i]` = 1 clears `DlRAM_wr_state[i]` and marks buffer i free.
  - A release with `wr_state[i]` = 0 is ignored.
- Buffers strictly alternate, 0,1,0,1…; a dropped frame does not toggle the target.
- Address arithmetic is base + idx, with no carry into the base bits. idx wraps to 0 on frame completion or restart.

## Timing
- `dinValid` accepted at edge N drives `wrRAMEn`/`wrRAMAddr`/`wrRAMData` during cycle N+1. The RAM write occurs at edge N+2.
- `DlRAM_wr_state[i]` rises in cycle N+2 after the last word (idx 37) is accepted at edge N. This is one cycle after that word's write strobe, so the RAM holds all 38 words before the reader can start.
- A release seen at edge M drops `DlRAM_wr_state[i]` in cycle M+2: one cycle for `rd_d` plus one cycle to register. This is well inside the reader's ≥20-cycle done window, so the reader never re-reads.
- A release and an SOF targeting the same buffer at the same edge: the free update and the SOF check share one registered decision. The SOF is evaluated against the pre-release state and is therefore dropped. This is deterministic and benches check for it.
- Back-to-back frames are allowed: an SOF in the cycle after the idx-37 word is accepted normally.
- Reset mid-frame: all state, including full flags, is cleared asynchronously. The partial frame is lost and `wr_state` goes 0 immediately.

## Structure
- Shared package `dl_ram_pkg`:
  - `DATA_W`, `ADDR_W`, `FRAME_WORDS`, `BUF0_BASE`, `BUF1_BASE` (also used by the read controller);
  - the write-state encoding S_IDLE/S_WR/S_DROP.
- Sub-module `dl_ram_buf_tracker`, instantiated ×2:
  - inputs: `set_full`, `rd_state_i`;
  - outputs: `wr_state_o`, `free_o`;
  - contains the `rd_d` edge register and the release logic.
- The top level holds the FSM, idx counter, target bit, write-port registers and overflow counter.

## Test plan
- After reset, 38 words with SOF on word 0 → addresses 0..37 written in order, with data matching. `wr_state` = 01 two cycles after the last word.
- Pulse `rd_state[0]` for 21 cycles → `wr_state[0]` clears two cycles after the rise. The next frame goes to addresses 64..101 and sets `wr_state` = 10.
- Two frames with no release, then a third frame → third frame dropped:
  - `ovfPulse` = 1 for one cycle;
  - `ovfCount` = 1;
  - no `wrRAMEn` during that frame;
  - `wr_state` stays 11.
- SOF at idx 20 of a frame → `sofErrPulse` = 1. Writing restarts at address 0 (or 64), and `wr_state` is unchanged until 38 words complete.
- Assert `nRst` at idx 15 → all outputs 0 immediately. After release of reset, the next frame writes to buffer 0.
- `rd_state[1]` pulsed while `wr_state[1]` = 0 → no state change. Then force `ovfCount` to saturation with drops → it holds at 16'hFFFF.
